// File: rtl/wfifo_wr_arb.sv
// Round-robin write arbiter feeding a FIFO write port: grants one requester at a time
// for a burst of up to MAX_BURST beats, with one idle cycle between grants.
module wfifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          last,
    input  logic [NREQ*DWIDTH-1:0]   din,
    input  logic                     wfull,
    output logic [NREQ-1:0]          gnt,
    output logic                     winc,
    output logic [DWIDTH-1:0]        wdata,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = IDW + 1;
    localparam int BW  = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [NREQ-1:0] GNT_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [0:0]        state_r;
    logic [NREQ-1:0]   gnt_r;
    logic [IDW-1:0]    gidx_r;
    logic [IDW-1:0]    last_id_r;
    logic [BW-1:0]     burst_cnt_r;

    logic [IDW-1:0]    pick_idx_s;
    logic [CW-1:0]     sum_s;
    logic [CW-1:0]     cand_s;
    logic [DWIDTH-1:0] din_a_s [NREQ];
    logic              cur_req_s;
    logic              cur_last_s;
    logic              beat_s;
    logic              release_s;
    logic [BW-1:0]     burst_nxt_s;

    // Rotating priority search; scanning from farthest to nearest leaves the nearest hit.
    always_comb begin
        pick_idx_s = last_id_r;
        sum_s      = {CW{1'b0}};
        cand_s     = {CW{1'b0}};
        for (int k = NREQ; k >= 1; k--) begin
            sum_s      = {1'b0, last_id_r} + CW'(k);
            cand_s     = (sum_s >= CW'(NREQ)) ? (sum_s - CW'(NREQ)) : sum_s;
            pick_idx_s = req[cand_s[IDW-1:0]] ? cand_s[IDW-1:0] : pick_idx_s;
        end
    end

    // Split the packed data bus into per-requester words.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            din_a_s[i] = din[i*DWIDTH +: DWIDTH];
        end
    end

    // Beat acceptance, release decision and FIFO write-side outputs for the granted requester.
    always_comb begin
        cur_req_s   = req[gidx_r];
        cur_last_s  = last[gidx_r];
        beat_s      = (state_r == ST_GRANT) && cur_req_s && !wfull;
        burst_nxt_s = burst_cnt_r + BW'(1);
        release_s   = (state_r == ST_GRANT) &&
                      (!cur_req_s || (beat_s && (cur_last_s || (burst_nxt_s == BW'(MAX_BURST)))));
        winc        = beat_s;
        wdata       = (state_r == ST_GRANT) ? din_a_s[gidx_r] : {DWIDTH{1'b0}};
    end

    // Grant state machine; wfull only stalls beats, it never ends a grant.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_r     <= ST_IDLE;
            gnt_r       <= {NREQ{1'b0}};
            gidx_r      <= {IDW{1'b0}};
            last_id_r   <= IDW'(NREQ - 1);
            burst_cnt_r <= {BW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req != {NREQ{1'b0}}) begin
                        state_r     <= ST_GRANT;
                        gnt_r       <= GNT_ONE << pick_idx_s;
                        gidx_r      <= pick_idx_s;
                        last_id_r   <= pick_idx_s;
                        burst_cnt_r <= {BW{1'b0}};
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (beat_s) begin
                        burst_cnt_r <= burst_nxt_s;
                    end else begin
                        burst_cnt_r <= burst_cnt_r;
                    end
                    if (release_s) begin
                        state_r <= ST_IDLE;
                        gnt_r   <= {NREQ{1'b0}};
                    end else begin
                        state_r <= ST_GRANT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= {NREQ{1'b0}};
                end
            endcase
        end
    end

    assign gnt  = gnt_r;
    assign busy = (state_r == ST_GRANT);

endmodule

// File: tb/tb_wfifo_wr_arb.sv
// Directed and random checks of wfifo_wr_arb against a round-robin burst model.
module tb_wfifo_wr_arb;

    localparam int NREQ      = 4;
    localparam int DWIDTH    = 8;
    localparam int MAX_BURST = 4;

    logic                   wclk   = 1'b0;
    logic                   wrst_n = 1'b1;
    logic [NREQ-1:0]        req    = '0;
    logic [NREQ-1:0]        last   = '0;
    logic [NREQ*DWIDTH-1:0] din    = 32'hD3C2B1A0;
    logic                   wfull  = 1'b0;
    logic [NREQ-1:0]        gnt;
    logic                   winc;
    logic [DWIDTH-1:0]      wdata;
    logic                   busy;

    int n_vec = 0;
    int n_err = 0;

    wfifo_wr_arb #(.NREQ(NREQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .last(last), .din(din),
        .wfull(wfull), .gnt(gnt), .winc(winc), .wdata(wdata), .busy(busy)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int from, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(from + k) % NREQ]) return (from + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: who holds the grant, how many beats it has moved, who was served last.
    bit m_busy = 1'b0;
    int m_g    = 0;
    int m_last = NREQ - 1;
    int m_cnt  = 0;

    initial begin : model
        int p;
        forever begin
            @(posedge wclk or negedge wrst_n);
            if (!wrst_n) begin
                m_busy = 1'b0; m_last = NREQ - 1; m_cnt = 0;
            end else if (!m_busy) begin
                p = rr_pick(m_last, req);
                if (p >= 0) begin
                    m_busy = 1'b1; m_g = p; m_last = p; m_cnt = 0;
                end
            end else if (!req[m_g]) begin
                m_busy = 1'b0;
            end else if (!wfull) begin
                m_cnt++;
                if (last[m_g] || m_cnt == MAX_BURST) m_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, plus one-hot, wfull and starvation properties.
    initial begin : cmp
        logic [NREQ-1:0]   e_gnt;
        logic              e_winc;
        logic [DWIDTH-1:0] e_wdata;
        logic [NREQ-1:0]   gprev;
        int                wt [NREQ];
        gprev = '0;
        foreach (wt[i]) wt[i] = 0;
        forever begin
            @(negedge wclk);
            e_gnt   = '0;
            e_winc  = 1'b0;
            e_wdata = '0;
            if (m_busy) begin
                e_gnt[m_g] = 1'b1;
                e_winc     = req[m_g] && !wfull;
                e_wdata    = din[m_g*DWIDTH +: DWIDTH];
            end
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("winc", 32'(winc), 32'(e_winc));
            check("wdata", 32'(wdata), 32'(e_wdata));
            check("busy", 32'(busy), 32'(m_busy));
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("winc_while_full", 32'(winc & wfull), 32'd0);
            for (int i = 0; i < NREQ; i++) begin
                if (!wrst_n || !req[i]) begin
                    wt[i] = 0;
                end else if (gnt != '0 && gprev == '0) begin
                    if (gnt[i]) begin
                        wt[i] = 0;
                    end else begin
                        wt[i]++;
                        check("starve_bound", (wt[i] <= NREQ - 1) ? 32'd1 : 32'd0, 32'd1);
                    end
                end
            end
            gprev = gnt;
        end
    end

    task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic wf);
        @(posedge wclk);
        #1;
        req = r; last = l; wfull = wf;
        @(negedge wclk);
    endtask

    initial begin : stim
        logic [NREQ-1:0]   gtbl [4];
        logic [DWIDTH-1:0] dtbl [4];
        logic [NREQ-1:0]   r;
        logic [NREQ-1:0]   l;
        int                wcnt;
        gtbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        dtbl = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

        #1 wrst_n = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        wrst_n = 1'b1; req = 4'b1111; last = '0; wfull = 1'b0;
        @(negedge wclk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // All four requesting: full bursts in rotation with an idle cycle between.
        for (int g = 0; g < 4; g++) begin
            wcnt = 0;
            if (g > 0) begin
                cyc(4'b1111, 4'b0000, 1'b0);
                check("s1_idle_gnt", 32'(gnt), 32'd0);
            end
            for (int b = 0; b < 4; b++) begin
                cyc(4'b1111, 4'b0000, 1'b0);
                check("s1_gnt", 32'(gnt), 32'(gtbl[g]));
                check("s1_wdata", 32'(wdata), 32'(dtbl[g]));
                wcnt += int'(winc);
            end
            check("s1_beats", 32'(wcnt), 32'd4);
        end

        // Requester 2 alone, last on the second beat.
        cyc(4'b0000, 4'b0000, 1'b0);
        check("s2_idle", 32'(gnt), 32'd0);
        wcnt = 0;
        cyc(4'b0100, 4'b0000, 1'b0);
        check("s2_arb_gnt", 32'(gnt), 32'd0);
        cyc(4'b0100, 4'b0000, 1'b0);
        check("s2_gnt1", 32'(gnt), 32'h4);
        wcnt += int'(winc);
        cyc(4'b0100, 4'b0100, 1'b0);
        check("s2_gnt2", 32'(gnt), 32'h4);
        wcnt += int'(winc);
        cyc(4'b0000, 4'b0000, 1'b0);
        check("s2_released", 32'(gnt), 32'd0);
        wcnt += int'(winc);
        check("s2_beats", 32'(wcnt), 32'd2);

        // Requester 1 stalled three cycles by wfull, others' req/last must be ignored.
        wcnt = 0;
        cyc(4'b0010, 4'b0000, 1'b0);
        check("s3_arb_gnt", 32'(gnt), 32'd0);
        cyc(4'b0010, 4'b0000, 1'b0);
        check("s3_gnt", 32'(gnt), 32'h2);
        wcnt += int'(winc);
        for (int s = 0; s < 3; s++) begin
            cyc(4'b1011, 4'b1101, 1'b1);
            check("s3_stall_gnt", 32'(gnt), 32'h2);
            check("s3_stall_winc", 32'(winc), 32'd0);
        end
        for (int b = 0; b < 3; b++) begin
            cyc(4'b0010, 4'b0000, 1'b0);
            check("s3_resume_gnt", 32'(gnt), 32'h2);
            check("s3_wdata", 32'(wdata), 32'hB1);
            wcnt += int'(winc);
        end
        cyc(4'b0000, 4'b0000, 1'b0);
        check("s3_released", 32'(gnt), 32'd0);
        check("s3_beats", 32'(wcnt), 32'd4);

        // Requester 3 drops req after one beat; requester 0 is next.
        cyc(4'b1000, 4'b0000, 1'b0);
        cyc(4'b1000, 4'b0000, 1'b0);
        check("s4_gnt", 32'(gnt), 32'h8);
        check("s4_winc", 32'(winc), 32'd1);
        check("s4_wdata", 32'(wdata), 32'hD3);
        cyc(4'b0001, 4'b0000, 1'b0);
        check("s4_drop_gnt", 32'(gnt), 32'h8);
        check("s4_drop_winc", 32'(winc), 32'd0);
        cyc(4'b0001, 4'b0001, 1'b0);
        check("s4_idle", 32'(gnt), 32'd0);
        cyc(4'b0001, 4'b0001, 1'b0);
        check("s4_next_gnt", 32'(gnt), 32'h1);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Reset in the middle of requester 2's burst.
        cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0100, 4'b0000, 1'b0);
        check("s5_gnt", 32'(gnt), 32'h4);
        #2 wrst_n = 1'b0;
        #1;
        check("s5_rst_gnt", 32'(gnt), 32'd0);
        check("s5_rst_winc", 32'(winc), 32'd0);
        check("s5_rst_wdata", 32'(wdata), 32'd0);
        check("s5_rst_busy", 32'(busy), 32'd0);
        repeat (2) begin
            cyc(4'b0100, 4'b0000, 1'b0);
            check("s5_hold_winc", 32'(winc), 32'd0);
        end
        @(posedge wclk);
        #1;
        wrst_n = 1'b1; req = 4'b0101;
        @(negedge wclk);
        check("s5_rel_gnt", 32'(gnt), 32'd0);
        cyc(4'b0101, 4'b0000, 1'b0);
        check("s5_first_gnt", 32'(gnt), 32'h1);
        check("s5_first_wdata", 32'(wdata), 32'hA0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Random traffic with slowly changing requests, checked by the compare process.
        r = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            end
            l = NREQ'($urandom_range(0, 15) & $urandom_range(0, 15));
            cyc(r, l, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
